// File: rtl/xout_window_stats_if.sv
// Bundle of signals between the windowed statistics block and its neighbours.
//   in_valid/xin/clear : sample stream from the upstream arithmetic stage (no backpressure)
//   out_valid/out_ready: record handshake toward the consumer
//   sum/vmin/vmax      : record payload
//   fill/drop_cnt      : status (samples in partial window, discarded records)
// Modports: master = environment side, slave = statistics block.
interface xout_window_stats_if #(
   parameter int NBITS  = 8,
   parameter int WINDOW = 16
);
   localparam int SW = NBITS + $clog2(WINDOW);
   localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

   logic             in_valid;
   logic [NBITS-1:0] xin;
   logic             clear;
   logic             out_valid;
   logic             out_ready;
   logic [SW-1:0]    sum;
   logic [NBITS-1:0] vmin;
   logic [NBITS-1:0] vmax;
   logic [CW-1:0]    fill;
   logic [7:0]       drop_cnt;

   modport master (
      output in_valid, xin, clear, out_ready,
      input  out_valid, sum, vmin, vmax, fill, drop_cnt
   );

   modport slave (
      input  in_valid, xin, clear, out_ready,
      output out_valid, sum, vmin, vmax, fill, drop_cnt
   );
endinterface

// File: rtl/xout_window_stats.sv
// Windowed statistics on the upstream XOUT stream: every WINDOW accepted
// samples produce one record (sum, min, max) offered on a valid/ready port.
// The input cannot be stalled, so a record completing while the previous one
// is still unconsumed is discarded and counted in a saturating drop counter.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : xout_window_stats_if.slave (sample input, record output, status)
//
// Window state, encoded by r_fill:
//   state | meaning
//   EMPTY | r_fill == 0, next accepted sample seeds acc/min/max
//   ACCUM | 0 < r_fill < WINDOW, accepted samples fold into acc/min/max
//   (the WINDOW-th accepted sample completes the record and returns to EMPTY)
module xout_window_stats #(
   parameter int NBITS  = 8,
   parameter int WINDOW = 16
) (
   input logic               i_clk,
   input logic               i_rst,
   xout_window_stats_if.slave bus
);
   localparam int SW = NBITS + $clog2(WINDOW);
   localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

   logic [CW-1:0]    r_fill;
   logic [SW-1:0]    r_acc;
   logic [NBITS-1:0] r_min;
   logic [NBITS-1:0] r_max;
   logic             r_out_valid;
   logic [SW-1:0]    r_sum;
   logic [NBITS-1:0] r_vmin;
   logic [NBITS-1:0] r_vmax;
   logic [7:0]       r_drop_cnt;

   logic             w_accept;
   logic             w_first;
   logic             w_complete;
   logic             w_xfer;
   logic             w_load;
   logic             w_drop;
   logic [SW-1:0]    w_acc_next;
   logic [NBITS-1:0] w_min_next;
   logic [NBITS-1:0] w_max_next;

   always_comb begin
      w_accept   = bus.in_valid & ~bus.clear;
      w_first    = (r_fill == '0);
      w_complete = w_accept & (r_fill == LAST);
      w_xfer     = r_out_valid & bus.out_ready;
      // A completing record may replace the held one in the same edge it is consumed.
      w_load     = w_complete & (~r_out_valid | bus.out_ready);
      w_drop     = w_complete & r_out_valid & ~bus.out_ready;
      if (w_first) begin
         w_acc_next = SW'(bus.xin);
         w_min_next = bus.xin;
         w_max_next = bus.xin;
      end else begin
         w_acc_next = r_acc + SW'(bus.xin);
         w_min_next = (bus.xin < r_min) ? bus.xin : r_min;
         w_max_next = (bus.xin > r_max) ? bus.xin : r_max;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fill      <= '0;
         r_acc       <= '0;
         r_min       <= '0;
         r_max       <= '0;
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_vmin      <= '0;
         r_vmax      <= '0;
         r_drop_cnt  <= '0;
      end else begin
         if (bus.clear) begin
            r_fill <= '0;
         end else if (bus.in_valid) begin
            r_fill <= w_complete ? '0 : r_fill + CW'(1);
            r_acc  <= w_acc_next;
            r_min  <= w_min_next;
            r_max  <= w_max_next;
         end

         if (w_load) begin
            r_sum       <= w_acc_next;
            r_vmin      <= w_min_next;
            r_vmax      <= w_max_next;
            r_out_valid <= 1'b1;
         end else if (w_xfer) begin
            r_out_valid <= 1'b0;
         end

         if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.sum       = r_sum;
   assign bus.vmin      = r_vmin;
   assign bus.vmax      = r_vmax;
   assign bus.fill      = r_fill;
   assign bus.drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_xout_window_stats.sv
module tb_xout_window_stats;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   xout_window_stats_if #(.NBITS(8), .WINDOW(4)) ifa ();
   xout_window_stats_if #(.NBITS(8), .WINDOW(1)) ifb ();

   xout_window_stats #(.NBITS(8), .WINDOW(4)) dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
   xout_window_stats #(.NBITS(8), .WINDOW(1)) dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));

   typedef struct packed {
      logic [9:0] sum;
      logic [7:0] vmin;
      logic [7:0] vmax;
   } rec_t;

   rec_t       q_a[$];
   logic [7:0] q_b[$];
   int n_pass  = 0;
   int n_total = 0;

   // reference window model for dut_a
   int ma_fill = 0;
   int ma_acc  = 0;
   int ma_min  = 0;
   int ma_max  = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic model_reset();
      ma_fill = 0;
      q_a.delete();
      q_b.delete();
   endtask

   // All-ones sum (1023) is unreachable for WINDOW=4, so an empty pop never matches.
   task automatic pop_a(output rec_t r);
      if (q_a.size() == 0) r = '1;
      else r = q_a.pop_front();
   endtask

   task automatic send_a(input int x);
      ifa.in_valid = 1'b1;
      ifa.xin      = 8'(x);
      if (ma_fill == 0) begin
         ma_acc = x; ma_min = x; ma_max = x;
      end else begin
         ma_acc += x;
         if (x < ma_min) ma_min = x;
         if (x > ma_max) ma_max = x;
      end
      ma_fill++;
      if (ma_fill == 4) begin
         q_a.push_back(rec_t'({10'(ma_acc), 8'(ma_min), 8'(ma_max)}));
         ma_fill = 0;
      end
      tick();
      ifa.in_valid = 1'b0;
   endtask

   task automatic clear_a(input int x);
      ifa.in_valid = 1'b1;
      ifa.xin      = 8'(x);
      ifa.clear    = 1'b1;
      ma_fill      = 0;
      tick();
      ifa.in_valid = 1'b0;
      ifa.clear    = 1'b0;
   endtask

   task automatic send_b(input int x);
      ifb.in_valid = 1'b1;
      ifb.xin      = 8'(x);
      q_b.push_back(8'(x));
      tick();
      ifb.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_total++;
      if ({ifa.out_valid, ifa.fill, ifa.sum, ifa.vmin, ifa.vmax, ifa.drop_cnt} !== '0)
         $display("FAIL reset_a: got %h want 0",
                  {ifa.out_valid, ifa.fill, ifa.sum, ifa.vmin, ifa.vmax, ifa.drop_cnt});
      else n_pass++;
      n_total++;
      if ({ifb.out_valid, ifb.sum, ifb.drop_cnt} !== '0)
         $display("FAIL reset_b: got %h want 0", {ifb.out_valid, ifb.sum, ifb.drop_cnt});
      else n_pass++;
      idle(2);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      rec_t e;
      ifa.out_ready = 1'b1;
      send_a(10); send_a(200); send_a(3); send_a(255);
      pop_a(e);
      n_total++;
      if (ifa.out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", ifa.out_valid);
      else n_pass++;
      n_total++;
      if ({ifa.sum, ifa.vmin, ifa.vmax} !== e)
         $display("FAIL basic_rec: got %h want %h", {ifa.sum, ifa.vmin, ifa.vmax}, e);
      else n_pass++;
      n_total++;
      if ({ifa.sum, ifa.vmin, ifa.vmax} !== {10'd468, 8'd3, 8'd255})
         $display("FAIL basic_const: got %0d/%0d/%0d want 468/3/255", ifa.sum, ifa.vmin, ifa.vmax);
      else n_pass++;
      n_total++;
      if ({ifa.fill, ifa.drop_cnt} !== 10'd0)
         $display("FAIL basic_fill_drop: got fill %0d drop %0d want 0 0", ifa.fill, ifa.drop_cnt);
      else n_pass++;
      tick();
      n_total++;
      if (ifa.out_valid !== 1'b0) $display("FAIL basic_consumed: got %b want 0", ifa.out_valid);
      else n_pass++;
   endtask

   task automatic test_bubbles();
      int xs[4] = '{10, 200, 3, 255};
      int k;
      rec_t e;
      ifa.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send_a(xs[i]);
         n_total++;
         if (ifa.fill !== 2'(ma_fill))
            $display("FAIL bubble_fill%0d: got %0d want %0d", i, ifa.fill, ma_fill);
         else n_pass++;
         if (i < 3) begin
            k = $urandom_range(1, 3);
            idle(k);
            n_total++;
            if (ifa.fill !== 2'(ma_fill))
               $display("FAIL bubble_hold%0d: got %0d want %0d", i, ifa.fill, ma_fill);
            else n_pass++;
         end
      end
      pop_a(e);
      n_total++;
      if ({ifa.out_valid, ifa.sum, ifa.vmin, ifa.vmax} !== {1'b1, 10'd468, 8'd3, 8'd255})
         $display("FAIL bubble_rec: got v%b %0d/%0d/%0d want v1 468/3/255",
                  ifa.out_valid, ifa.sum, ifa.vmin, ifa.vmax);
      else n_pass++;
      n_total++;
      if ({ifa.sum, ifa.vmin, ifa.vmax} !== e)
         $display("FAIL bubble_sb: got %h want %h", {ifa.sum, ifa.vmin, ifa.vmax}, e);
      else n_pass++;
      tick();
   endtask

   task automatic test_backpressure();
      rec_t held, e;
      ifa.out_ready = 1'b0;
      for (int v = 1; v <= 4; v++) send_a(v);
      pop_a(held);
      n_total++;
      if ({ifa.out_valid, ifa.sum, ifa.vmin, ifa.vmax} !== {1'b1, 10'd10, 8'd1, 8'd4})
         $display("FAIL bp_first: got v%b %0d/%0d/%0d want v1 10/1/4",
                  ifa.out_valid, ifa.sum, ifa.vmin, ifa.vmax);
      else n_pass++;
      for (int v = 5; v <= 8; v++) send_a(v);
      pop_a(e);
      n_total++;
      if ({ifa.sum, ifa.vmin, ifa.vmax} !== held)
         $display("FAIL bp_held: got %h want %h", {ifa.sum, ifa.vmin, ifa.vmax}, held);
      else n_pass++;
      n_total++;
      if (ifa.drop_cnt !== 8'd1) $display("FAIL bp_drop1: got %0d want 1", ifa.drop_cnt);
      else n_pass++;
      ifa.out_ready = 1'b1;
      tick();
      ifa.out_ready = 1'b0;
      n_total++;
      if (ifa.out_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", ifa.out_valid);
      else n_pass++;
      // First window reloads the register, the next 299 are all dropped: 300 drops total.
      for (int w = 0; w < 300; w++) begin
         for (int s = 0; s < 4; s++) send_a($urandom_range(0, 255));
         if (w == 0) pop_a(held);
         else pop_a(e);
         if (w == 253) begin
            n_total++;
            if (ifa.drop_cnt !== 8'd254) $display("FAIL bp_drop254: got %0d want 254", ifa.drop_cnt);
            else n_pass++;
         end
      end
      n_total++;
      if (ifa.drop_cnt !== 8'd255) $display("FAIL bp_sat: got %0d want 255", ifa.drop_cnt);
      else n_pass++;
      n_total++;
      if ({ifa.out_valid, ifa.sum, ifa.vmin, ifa.vmax} !== {1'b1, held})
         $display("FAIL bp_held2: got %h want %h", {ifa.out_valid, ifa.sum, ifa.vmin, ifa.vmax},
                  {1'b1, held});
      else n_pass++;
      ifa.out_ready = 1'b1;
      tick();
   endtask

   task automatic test_clear();
      rec_t e;
      ifa.out_ready = 1'b1;
      send_a(5); send_a(6);
      clear_a(99);
      n_total++;
      if (ifa.fill !== 2'd0) $display("FAIL clr_fill: got %0d want 0", ifa.fill);
      else n_pass++;
      for (int i = 0; i < 4; i++) send_a(1);
      pop_a(e);
      n_total++;
      if ({ifa.out_valid, ifa.sum, ifa.vmin, ifa.vmax} !== {1'b1, 10'd4, 8'd1, 8'd1})
         $display("FAIL clr_rec: got v%b %0d/%0d/%0d want v1 4/1/1",
                  ifa.out_valid, ifa.sum, ifa.vmin, ifa.vmax);
      else n_pass++;
      n_total++;
      if ({ifa.sum, ifa.vmin, ifa.vmax} !== e)
         $display("FAIL clr_sb: got %h want %h", {ifa.sum, ifa.vmin, ifa.vmax}, e);
      else n_pass++;
      n_total++;
      if (ifa.drop_cnt !== 8'd255) $display("FAIL clr_drop: got %0d want 255", ifa.drop_cnt);
      else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] e;
      ifb.out_ready = 1'b1;
      send_b(7);
      e = (q_b.size() != 0) ? q_b.pop_front() : 8'hxx;
      n_total++;
      if ({ifb.out_valid, ifb.sum} !== {1'b1, e})
         $display("FAIL w1_first: got v%b %0d want v1 %0d", ifb.out_valid, ifb.sum, e);
      else n_pass++;
      send_b(9);
      e = (q_b.size() != 0) ? q_b.pop_front() : 8'hxx;
      n_total++;
      if ({ifb.out_valid, ifb.sum, ifb.vmin, ifb.vmax} !== {1'b1, e, e, e})
         $display("FAIL w1_second: got v%b %0d/%0d/%0d want v1 %0d/%0d/%0d",
                  ifb.out_valid, ifb.sum, ifb.vmin, ifb.vmax, e, e, e);
      else n_pass++;
      n_total++;
      if ({ifb.sum, ifb.drop_cnt} !== {8'd9, 8'd0})
         $display("FAIL w1_drop: got sum %0d drop %0d want 9 0", ifb.sum, ifb.drop_cnt);
      else n_pass++;
      tick();
   endtask

   task automatic test_async_reset();
      rec_t e;
      ifa.out_ready = 1'b1;
      send_a(50); send_a(50); send_a(50);
      #2 rst = 1'b1;
      #1;
      n_total++;
      if ({ifa.out_valid, ifa.fill, ifa.sum, ifa.drop_cnt} !== '0)
         $display("FAIL arst_mid: got v%b fill %0d sum %0d drop %0d want all 0",
                  ifa.out_valid, ifa.fill, ifa.sum, ifa.drop_cnt);
      else n_pass++;
      tick();
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) send_a(2);
      pop_a(e);
      n_total++;
      if ({ifa.out_valid, ifa.sum, ifa.vmin, ifa.vmax} !== {1'b1, 10'd8, 8'd2, 8'd2})
         $display("FAIL arst_after: got v%b %0d/%0d/%0d want v1 8/2/2",
                  ifa.out_valid, ifa.sum, ifa.vmin, ifa.vmax);
      else n_pass++;
      ifa.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_a(3);
      pop_a(e);
      n_total++;
      if ({ifa.out_valid, ifa.sum, ifa.drop_cnt} !== {1'b1, 10'd8, 8'd1})
         $display("FAIL arst_pend: got v%b sum %0d drop %0d want v1 8 1",
                  ifa.out_valid, ifa.sum, ifa.drop_cnt);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_total++;
      if ({ifa.out_valid, ifa.sum, ifa.vmin, ifa.vmax, ifa.drop_cnt} !== '0)
         $display("FAIL arst_held: got %h want 0",
                  {ifa.out_valid, ifa.sum, ifa.vmin, ifa.vmax, ifa.drop_cnt});
      else n_pass++;
      tick();
      rst = 1'b0;
      model_reset();
      ifa.out_ready = 1'b1;
      idle(2);
      n_total++;
      if ({ifa.out_valid, ifa.fill} !== 3'b000)
         $display("FAIL arst_noemit: got v%b fill %0d want v0 0", ifa.out_valid, ifa.fill);
      else n_pass++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ifa.in_valid = 1'b0; ifa.xin = '0; ifa.clear = 1'b0; ifa.out_ready = 1'b0;
      ifb.in_valid = 1'b0; ifb.xin = '0; ifb.clear = 1'b0; ifb.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_bubbles();
      test_backpressure();
      test_clear();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
